alu_exec_unit: RTL and testbench

Execution-side counterpart of the ALU controller: consumes the 3-bit ALU operation code and the flag-start strobe, performs the operation on two operands and holds the result and an NZCV status register. Sits in the datapath between the register file read ports and the writeback mux. Uses a registered three-state issue/execute/complete handshake so the multi-cycle main controller can sequence it.

---
 rtl/alu_exec_unit_pkg.sv | 32 +++
 rtl/alu_exec_unit_alu_core.sv | 83 ++++++++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU controller/execution pair: op codes, NZCV bit
// positions and the issue/execute/complete state encoding.
package alu_exec_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_RSB = 3'b010,
        OP_AND = 3'b011,
        OP_NOT = 3'b100,
        OP_TST = 3'b101,
        OP_CMP = 3'b110,
        OP_MOV = 3'b111
    } alu_op_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } exec_state_e;

    // TST and CMP only produce flags; every other op writes back.
    function automatic logic op_writes_result(input alu_op_e op);
        return !((op == OP_TST) || (op == OP_CMP));
    endfunction

endpackage

// File: rtl/alu_exec_unit_alu_core.sv
// Combinational ALU datapath: one shared adder serves ADD/SUB/CMP/RSB,
// logic ops pass the incoming C/V through unchanged.
module alu_core
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  alu_op_e           op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              c_in,
    input  logic              v_in,
    output logic [WIDTH-1:0]  value,
    output logic              n,
    output logic              z,
    output logic              c,
    output logic              v
);

    logic [WIDTH-1:0] add_x_s;
    logic [WIDTH-1:0] add_y_s;
    logic             add_cin_s;
    logic [WIDTH:0]   sum_s;
    logic             arith_s;

    // Select adder operands; subtraction is x + ~y + 1 so C means "no borrow".
    always_comb begin
        add_x_s   = {WIDTH{1'b0}};
        add_y_s   = {WIDTH{1'b0}};
        add_cin_s = 1'b0;
        arith_s   = 1'b0;
        case (op)
            OP_ADD: begin
                add_x_s = a;
                add_y_s = b;
                arith_s = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                add_x_s   = a;
                add_y_s   = ~b;
                add_cin_s = 1'b1;
                arith_s   = 1'b1;
            end
            OP_RSB: begin
                add_x_s   = b;
                add_y_s   = ~a;
                add_cin_s = 1'b1;
                arith_s   = 1'b1;
            end
            default: begin
                add_x_s   = {WIDTH{1'b0}};
                add_y_s   = {WIDTH{1'b0}};
                add_cin_s = 1'b0;
                arith_s   = 1'b0;
            end
        endcase
        sum_s = {1'b0, add_x_s} + {1'b0, add_y_s} + {{WIDTH{1'b0}}, add_cin_s};
    end

    // Result value and NZCV; V compares adder input signs against the sum sign.
    always_comb begin
        value = {WIDTH{1'b0}};
        c     = c_in;
        v     = v_in;
        case (op)
            OP_AND, OP_TST: value = a & b;
            OP_NOT:         value = ~b;
            OP_MOV:         value = b;
            default:        value = sum_s[WIDTH-1:0];
        endcase
        if (arith_s) begin
            c = sum_s[WIDTH];
            v = (add_x_s[WIDTH-1] == add_y_s[WIDTH-1]) &&
                (sum_s[WIDTH-1] != add_x_s[WIDTH-1]);
        end else begin
            c = c_in;
            v = v_in;
        end
        n = value[WIDTH-1];
        z = (value == {WIDTH{1'b0}});
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execution unit: captures an issued op, evaluates it for one cycle and
// presents result/NZCV with a one-cycle done pulse.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        alu_operation,
    input  logic              flag_start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              result_we,
    output logic [3:0]        flags
);

    exec_state_e      state_r;
    alu_op_e          op_r;
    logic             flag_start_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [WIDTH-1:0] core_value_s;
    logic             core_n_s;
    logic             core_z_s;
    logic             core_c_s;
    logic             core_v_s;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .op    (op_r),
        .a     (a_r),
        .b     (b_r),
        .c_in  (flags[FLAG_C]),
        .v_in  (flags[FLAG_V]),
        .value (core_value_s),
        .n     (core_n_s),
        .z     (core_z_s),
        .c     (core_c_s),
        .v     (core_v_s)
    );

    // Issue/execute/complete sequencer with registered handshake and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            op_r         <= OP_ADD;
            flag_start_r <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            busy         <= 1'b0;
            done         <= 1'b0;
            result_we    <= 1'b0;
            result       <= {WIDTH{1'b0}};
            flags        <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done      <= 1'b0;
                    result_we <= 1'b0;
                    if (start) begin
                        state_r      <= ST_EXEC;
                        op_r         <= alu_op_e'(alu_operation);
                        flag_start_r <= flag_start;
                        a_r          <= a;
                        b_r          <= b;
                        busy         <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_EXEC: begin
                    state_r   <= ST_DONE;
                    busy      <= 1'b1;
                    done      <= 1'b1;
                    result_we <= op_writes_result(op_r);
                    if (op_writes_result(op_r)) begin
                        result <= core_value_s;
                    end
                    if (flag_start_r) begin
                        flags <= {core_n_s, core_z_s, core_c_s, core_v_s};
                    end
                end
                ST_DONE: begin
                    // A start seen here is dropped; the next issue needs IDLE.
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    result_we <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    result_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] alu_operation;
    logic       flag_start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       result_we;
    logic [3:0] flags;

    int tests_run = 0;
    int fails     = 0;

    logic [7:0] model_result;
    logic [3:0] model_flags;

    alu_exec_unit #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .alu_operation (alu_operation),
        .flag_start    (flag_start),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .result_we     (result_we),
        .flags         (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the op semantics.
    task automatic ref_op(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                          input logic fs, output logic we);
        int ua, ub, sa, sb, full, sfull, val;
        logic c, v, nf, zf;
        ua = int'(av); ub = int'(bv);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        c = model_flags[1];
        v = model_flags[0];
        full = 0; sfull = 0; val = 0;
        case (op)
            3'd0: begin full = ua + ub; sfull = sa + sb; c = (full > 255); v = (sfull > 127) || (sfull < -128); val = full & 255; end
            3'd1, 3'd6: begin full = ua - ub; sfull = sa - sb; c = (ua >= ub); v = (sfull > 127) || (sfull < -128); val = full & 255; end
            3'd2: begin full = ub - ua; sfull = sb - sa; c = (ub >= ua); v = (sfull > 127) || (sfull < -128); val = full & 255; end
            3'd3, 3'd5: val = ua & ub;
            3'd4: val = (~ub) & 255;
            default: val = ub;
        endcase
        nf = (val >= 128);
        zf = (val == 0);
        we = !((op == 3'd5) || (op == 3'd6));
        if (we) model_result = 8'(val);
        if (fs) model_flags = {nf, zf, c, v};
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] av,
                         input logic [7:0] bv, input logic fs);
        logic exp_we;
        logic [7:0] prev_res;
        prev_res = model_result;
        @(negedge clk);
        start = 1'b1; alu_operation = op; a = av; b = bv; flag_start = fs;
        @(posedge clk); #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        alu_operation = 3'($urandom); flag_start = 1'($urandom);
        ref_op(op, av, bv, fs, exp_we);
        @(negedge clk);
        check({tag, ".exec_busy"}, 32'(busy), 32'd1);
        check({tag, ".exec_done"}, 32'(done), 32'd0);
        check({tag, ".exec_result"}, 32'(result), 32'(prev_res));
        @(negedge clk);
        check({tag, ".done"}, 32'(done), 32'd1);
        check({tag, ".we"}, 32'(result_we), 32'(exp_we));
        check({tag, ".result"}, 32'(result), 32'(model_result));
        check({tag, ".flags"}, 32'(flags), 32'(model_flags));
        @(negedge clk);
        check({tag, ".idle_done"}, 32'(done), 32'd0);
        check({tag, ".idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int pulses;
        logic exp_we;
        rst_n = 1'b0; start = 1'b0; alu_operation = 3'd0; flag_start = 1'b0;
        a = 8'h00; b = 8'h00;
        model_result = 8'h00; model_flags = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.we", 32'(result_we), 32'd0);
        check("rst.result", 32'(result), 32'h00);
        check("rst.flags", 32'(flags), 32'h0);
        rst_n = 1'b1;

        do_op("add_ovf", 3'd0, 8'h7F, 8'h01, 1'b1);
        check("add_ovf.nzcv", 32'(flags), 32'b1001);
        do_op("sub_eq", 3'd1, 8'h05, 8'h05, 1'b1);
        check("sub_eq.nzcv", 32'(flags), 32'b0110);
        do_op("rsb", 3'd2, 8'h05, 8'h03, 1'b1);
        check("rsb.val", 32'(result), 32'hFE);
        do_op("mov_aa", 3'd7, 8'h00, 8'hAA, 1'b0);
        do_op("cmp", 3'd6, 8'h10, 8'h20, 1'b1);
        check("cmp.hold", 32'(result), 32'hAA);
        check("cmp.nzcv", 32'(flags), 32'b1000);
        do_op("preload", 3'd1, 8'h80, 8'h01, 1'b1);
        check("preload.nzcv", 32'(flags), 32'b0011);
        do_op("and_nf", 3'd3, 8'hF0, 8'h0F, 1'b0);
        check("and_nf.nzcv", 32'(flags), 32'b0011);
        do_op("tst", 3'd5, 8'hF0, 8'h0F, 1'b1);
        check("tst.nzcv", 32'(flags), 32'b0111);

        // start held high: issue every third cycle, busy low only while idle.
        @(negedge clk);
        start = 1'b1; alu_operation = 3'd7; a = 8'($urandom); b = 8'h3C; flag_start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) pulses++;
            check($sformatf("held.done%0d", i), 32'(done), 32'((i % 3) == 1));
            check($sformatf("held.busy%0d", i), 32'(busy), 32'((i % 3) != 2));
        end
        start = 1'b0;
        check("held.pulses", 32'(pulses), 32'd3);
        repeat (2) @(negedge clk);
        ref_op(3'd7, 8'h00, 8'h3C, 1'b0, exp_we);
        check("held.result", 32'(result), 32'h3C);
        check("held.idle", 32'(busy), 32'd0);

        // Reset during EXEC discards the op.
        @(negedge clk);
        start = 1'b1; alu_operation = 3'd0; a = 8'hFF; b = 8'h01; flag_start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("rmid.exec", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_result = 8'h00; model_flags = 4'b0000;
        check("rmid.busy", 32'(busy), 32'd0);
        check("rmid.done", 32'(done), 32'd0);
        check("rmid.result", 32'(result), 32'h00);
        check("rmid.flags", 32'(flags), 32'h0);
        @(negedge clk);
        check("rmid.nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        start = 1'b1; alu_operation = 3'd7; a = 8'h00; b = 8'h5A; flag_start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ref_op(3'd7, 8'h00, 8'h5A, 1'b1, exp_we);
        @(negedge clk);
        check("rmid.accept", 32'(busy), 32'd1);
        @(negedge clk);
        check("rmid.done2", 32'(done), 32'd1);
        check("rmid.res2", 32'(result), 32'(model_result));
        check("rmid.flags2", 32'(flags), 32'(model_flags));
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rnd%0d", i), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
